// File: rtl/adcxx1s101_multi.sv
// Multi-channel controller for TI ADCXX1S101 ADCs sharing one chip-select and SCLK.
// Define ADC_SAMPLE_COUNT_EN to add the 16-bit sampleCount output.
module adcxx1s101_multi #(
  parameter int ADC_RES      = 12,
  parameter int NUM_CH       = 4,
  parameter int CONV_CYCLES  = 16,
  parameter int HOLD_CYCLES  = 3,
  parameter int QUIET_CYCLES = 4,
  parameter int INVERT_MISO  = 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      startCapture,
  input  logic                      freeRun,
  input  logic [7:0]                rateDiv,
  input  logic [NUM_CH-1:0]         miso,
  output logic                      cs,
  output logic [NUM_CH*ADC_RES-1:0] dataout,
  output logic                      dataValid,
  output logic                      conversionComplete,
  output logic                      busy
`ifdef ADC_SAMPLE_COUNT_EN
  ,
  output logic [15:0]               sampleCount
`endif
);

  localparam int TRAIL_CYCLES = CONV_CYCLES - HOLD_CYCLES - ADC_RES;

  if (CONV_CYCLES < HOLD_CYCLES + ADC_RES) begin : gBadConv
    $error("CONV_CYCLES must be at least HOLD_CYCLES + ADC_RES");
  end
  if (ADC_RES != 8 && ADC_RES != 10 && ADC_RES != 12) begin : gBadRes
    $error("ADC_RES must be 8, 10 or 12");
  end
  if (NUM_CH < 1 || NUM_CH > 8) begin : gBadCh
    $error("NUM_CH must be in 1..8");
  end
  if (HOLD_CYCLES < 1 || QUIET_CYCLES < 1) begin : gBadPhase
    $error("HOLD_CYCLES and QUIET_CYCLES must be at least 1");
  end

  typedef enum logic [2:0] {IDLE, LEAD, SHIFT, TRAIL, QUIET, GAP} stateT;

  stateT       stateReg, stateNext;
  logic [15:0] cntReg, cntNext;     // cycles remaining in the current phase, including this one
  logic        armedReg, armedNext;
  logic        runReg, runNext;     // current conversion was started by freeRun
  logic        loadReg, loadNext;   // last data bit was captured on the previous edge
  logic        csReg, busyReg, dataValidReg, ccReg;
  logic [NUM_CH*ADC_RES-1:0]      dataoutReg;
  logic [NUM_CH-1:0][ADC_RES-1:0] shiftReg, shiftNext;
  logic [NUM_CH-1:0]              misoBit;

  always_comb begin
    stateNext = stateReg;
    cntNext   = cntReg;
    armedNext = armedReg | startCapture;
    runNext   = runReg;
    loadNext  = 1'b0;
    case (stateReg)
      IDLE: begin
        if (freeRun) begin
          stateNext = LEAD;
          cntNext   = 16'(HOLD_CYCLES);
          runNext   = 1'b1;
        end else if (!startCapture && armedReg) begin
          stateNext = LEAD;
          cntNext   = 16'(HOLD_CYCLES);
          runNext   = 1'b0;
          armedNext = 1'b0;
        end
      end
      LEAD: begin
        if (cntReg == 16'd1) begin
          stateNext = SHIFT;
          cntNext   = 16'(ADC_RES);
        end else begin
          cntNext = cntReg - 16'd1;
        end
      end
      SHIFT: begin
        if (cntReg == 16'd1) begin
          loadNext = 1'b1;
          if (TRAIL_CYCLES == 0) begin
            stateNext = QUIET;
            cntNext   = 16'(QUIET_CYCLES);
          end else begin
            stateNext = TRAIL;
            cntNext   = 16'(TRAIL_CYCLES);
          end
        end else begin
          cntNext = cntReg - 16'd1;
        end
      end
      TRAIL: begin
        if (cntReg == 16'd1) begin
          stateNext = QUIET;
          cntNext   = 16'(QUIET_CYCLES);
        end else begin
          cntNext = cntReg - 16'd1;
        end
      end
      QUIET: begin
        if (cntReg == 16'd1) begin
          if (runReg && rateDiv != 8'd0) begin
            stateNext = GAP;
            cntNext   = {8'd0, rateDiv};
          end else begin
            stateNext = IDLE;
          end
        end else begin
          cntNext = cntReg - 16'd1;
        end
      end
      GAP: begin
        if (cntReg == 16'd1) begin
          stateNext = IDLE;
        end else begin
          cntNext = cntReg - 16'd1;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  assign misoBit = (INVERT_MISO != 0) ? ~miso : miso;

  genvar gi;
  for (gi = 0; gi < NUM_CH; gi++) begin : gCh
    assign shiftNext[gi] = (stateReg == SHIFT) ? {shiftReg[gi][ADC_RES-2:0], misoBit[gi]}
                                               : shiftReg[gi];
  end

  // cs and busy are registered from the next state so the ADC sees a glitch-free select
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stateReg <= QUIET;
      cntReg   <= 16'(QUIET_CYCLES);
      armedReg <= 1'b0;
      runReg   <= 1'b0;
      loadReg  <= 1'b0;
      csReg    <= 1'b1;
      busyReg  <= 1'b1;
      shiftReg <= '0;
    end else begin
      stateReg <= stateNext;
      cntReg   <= cntNext;
      armedReg <= armedNext;
      runReg   <= runNext;
      loadReg  <= loadNext;
      csReg    <= !(stateNext inside {LEAD, SHIFT, TRAIL});
      busyReg  <= (stateNext != IDLE);
      shiftReg <= shiftNext;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dataoutReg   <= '0;
      dataValidReg <= 1'b0;
      ccReg        <= 1'b1;
    end else begin
      dataValidReg <= loadReg;
      if (loadReg) begin
        dataoutReg <= shiftReg;
      end
      if (loadReg && !runReg && !startCapture) begin
        ccReg <= 1'b0;
      end else if (startCapture && !ccReg) begin
        ccReg <= 1'b1;
      end
    end
  end

`ifdef ADC_SAMPLE_COUNT_EN
  logic [15:0] sampleCountReg;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sampleCountReg <= 16'd0;
    end else if (loadReg) begin
      sampleCountReg <= sampleCountReg + 16'd1;
    end
  end
  assign sampleCount = sampleCountReg;
`endif

  assign cs                 = csReg;
  assign busy               = busyReg;
  assign dataout            = dataoutReg;
  assign dataValid          = dataValidReg;
  assign conversionComplete = ccReg;

endmodule
